// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit whose decimal point acts as the minutes/seconds colon
    localparam int unsigned COLON_DIG = 2;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit bus in, display pins out, for the 7-segment scan driver.
interface seg7_scan_driver_if;
    logic [15:0] nums;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output nums, input an, input seg, input dp);
    modport slave  (input nums, output an, output seg, output dp);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; 10-15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver with blank guard,
// per-frame input latch and blinking colon. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD_CYC   = 16,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [15:0]      shd_q, shd_d;
    logic [BLK_W-1:0] bcnt_q, bcnt_d;
    logic             blk_q, blk_d;
    slot_state_e      state_q, state_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_wrap_c;
    logic             blink_wrap_c;
    logic             lead_blank_c;
    logic [3:0]       nib_c;
    logic [6:0]       dec_seg_c;

    assign slot_wrap_c  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign blink_wrap_c = (bcnt_q == BLK_W'(BLINK_DIV - 1));
    assign nib_c        = shd_q[{dig_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lead_blank_c = (dig_q == 2'd3) && (shd_q[15:12] == 4'd0);
`else
    assign lead_blank_c = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .bcd   (nib_c),
        .seg_c (dec_seg_c)
    );

    // Slot counter, digit index, frame latch and blink phase
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        dig_d  = dig_q;
        shd_d  = shd_q;
        bcnt_d = bcnt_q + BLK_W'(1);
        blk_d  = blk_q;
        if (slot_wrap_c) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end
        if ((cnt_q == '0) && (dig_q == 2'd0)) begin
            shd_d = bus.nums;
        end
        if (blink_wrap_c) begin
            bcnt_d = '0;
            blk_d  = ~blk_q;
        end
    end

    // Slot FSM plus next pin values; state tracks the region cnt_q is in
    always_comb begin
        state_d = state_q;
        an_d    = 4'hF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        case (state_q)
            ST_GUARD: if (cnt_q == CNT_W'(GUARD_CYC - 1)) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap_c) state_d = ST_GUARD;
            default:  state_d = ST_GUARD;
        endcase
        if (state_q == ST_SHOW) begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = lead_blank_c ? SEG_BLANK : dec_seg_c;
            dp_d  = ~(blk_q && (dig_q == 2'(COLON_DIG)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            shd_q   <= 16'h0000;
            bcnt_q  <= '0;
            blk_q   <= 1'b0;
            state_q <= ST_GUARD;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            shd_q   <= shd_d;
            bcnt_q  <= bcnt_d;
            blk_q   <= blk_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, GUARD_CYC=2, BLINK_DIV=20.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_seg7_scan_driver;

    localparam int unsigned REFRESH_DIV = 8;
    localparam int unsigned GUARD_CYC   = 2;
    localparam int unsigned BLINK_DIV   = 20;
    localparam int unsigned FRAME       = 4 * REFRESH_DIV;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    logic clk;
    logic rst;
    seg7_scan_driver_if bus ();

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    logic [15:0] frame_val = 16'h0000;

    seg7_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYC   (GUARD_CYC),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Pins after the k-th rising edge since release reflect cycle k-1 of the scan
    task automatic check_pins(input int kk);
        int c, d;
        bit shown, blk;
        logic [3:0] e_an, nib;
        logic [6:0] e_seg;
        logic e_dp;
        c     = (kk - 1) % REFRESH_DIV;
        d     = ((kk - 1) / REFRESH_DIV) % 4;
        shown = (c >= GUARD_CYC);
        blk   = (((kk - 1) / BLINK_DIV) % 2) == 1;
        nib   = frame_val[d*4 +: 4];
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (shown) begin
            e_an  = 4'hF & ~(4'b0001 << d);
            e_seg = (LZ_BLANK && d == 3 && nib == 4'd0) ? 7'h7F : dec(nib);
            e_dp  = !(d == 2 && blk);
        end
        check_eq($sformatf("an k=%0d", kk),  {12'h0, bus.an},  {12'h0, e_an});
        check_eq($sformatf("seg k=%0d", kk), {9'h0, bus.seg},  {9'h0, e_seg});
        check_eq($sformatf("dp k=%0d", kk),  {15'h0, bus.dp},  {15'h0, e_dp});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            k++;
            if ((k - 1) % FRAME == 0) frame_val = bus.nums;
            @(posedge clk);
            @(negedge clk);
            check_pins(k);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check_eq({tag, " an"},  {12'h0, bus.an}, 16'h000F);
        check_eq({tag, " seg"}, {9'h0, bus.seg}, 16'h007F);
        check_eq({tag, " dp"},  {15'h0, bus.dp}, 16'h0001);
    endtask

    initial begin
        rst      = 1'b0;
        bus.nums = 16'h1234;
        repeat (3) @(negedge clk);
        check_reset_pins("in_reset");
        rst = 1'b1;
        k   = 0;

        // Frame 0: scan order of 1234; mid-frame change must not tear
        run(12);
        bus.nums = 16'h5678;
        run(20);
        // Frame 1 shows 5678; queue invalid BCD for frames 2 and 3 (both blink phases)
        run(16);
        bus.nums = 16'h0A00;
        run(80);
        bus.nums = 16'h0905;
        run(32);
        // Into frame 5, digit 2 SHOW
        run(19);
        check_eq("pre_reset an", {12'h0, bus.an}, 16'h000B);

        #2 rst = 1'b0;
        #1 check_reset_pins("async_reset");
        bus.nums = 16'h4321;
        repeat (2) @(negedge clk);
        check_reset_pins("held_reset");
        rst = 1'b1;
        k   = 0;
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
